// File: rtl/sysbus_pkg.sv
// Shared definitions for the 13-bit-tag / 64-bit system bus.
// Initiators and the memory responder all import this package.
package sysbus_pkg;

  localparam int unsigned TAG_DEV_BIT = 12;
  localparam int unsigned TAG_OP_LSB  = 8;
  localparam int unsigned TAG_OP_W    = 4;
  localparam int unsigned LINE_BEATS  = 8;

  localparam logic                SYSBUS_MEMORY = 1'b1;
  localparam logic [TAG_OP_W-1:0] SYSBUS_READ   = 4'h1;
  localparam logic [TAG_OP_W-1:0] SYSBUS_WRITE  = 4'h2;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StLat,
    StResp,
    StWdata
  } sysbus_state_e;

endpackage

// File: rtl/sysbus_mem_array.sv
// Backing word array: one write port shared by bus and backdoor (bus wins),
// one asynchronous read port. Contents are never reset.
module sysbus_mem_array #(
  parameter int unsigned DataW = 64,
  parameter int unsigned Words = 4096,
  parameter int unsigned IdxW  = 12
) (
  input  logic             clk_i,
  input  logic             bus_we_i,
  input  logic [IdxW-1:0]  bus_idx_i,
  input  logic [DataW-1:0] bus_wdata_i,
  input  logic             bd_we_i,
  input  logic [IdxW-1:0]  bd_idx_i,
  input  logic [DataW-1:0] bd_wdata_i,
  input  logic [IdxW-1:0]  rd_idx_i,
  output logic [DataW-1:0] rd_data_o
);

  logic [DataW-1:0] mem_q [Words];

  always_ff @(posedge clk_i) begin
    if (bus_we_i) begin
      mem_q[bus_idx_i] <= bus_wdata_i;
    end else if (bd_we_i) begin
      mem_q[bd_idx_i] <= bd_wdata_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side responder: one request at a time, 8-beat critical-word-first line reads
// and 8-beat line writes into an internal word array.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respack,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bd_we,
  input  logic [63:0]               bd_addr,
  input  logic [BUS_DATA_WIDTH-1:0] bd_data
);

  localparam int unsigned IdxW  = $clog2(MEM_WORDS);
  localparam int unsigned LineW = IdxW - 3;
  localparam logic [2:0]  LastBeat = 3'(LINE_BEATS - 1);

  sysbus_state_e           state_q;
  logic [LineW-1:0]        line_q;
  logic [2:0]              off_q;
  logic [BUS_TAG_WIDTH-1:0] tag_q;
  logic [2:0]              beat_q;
  logic [15:0]             lat_q;

  logic                    req_hit;
  logic                    wr_beat;
  logic [TAG_OP_W-1:0]     op;
  logic [IdxW-1:0]         beat_idx;
  logic [BUS_DATA_WIDTH-1:0] rd_data;

  assign req_hit = bus_reqcyc && (bus_reqtag[TAG_DEV_BIT] == SYSBUS_MEMORY);
  assign wr_beat = (state_q == StWdata) && bus_reqcyc;
  assign op      = tag_q[TAG_OP_LSB +: TAG_OP_W];
  // Offset wraps in 3 bits so the burst never leaves its line.
  assign beat_idx = {line_q, off_q + beat_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      line_q  <= '0;
      off_q   <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_hit) begin
            line_q  <= bus_req[IdxW+2:6];
            off_q   <= bus_req[5:3];
            tag_q   <= bus_reqtag;
            state_q <= StAck;
          end
        end
        StAck: begin
          beat_q <= '0;
          lat_q  <= 16'd1;
          if (op == SYSBUS_READ) begin
            state_q <= (READ_LATENCY == 1) ? StResp : StLat;
          end else if (op == SYSBUS_WRITE) begin
            state_q <= StWdata;
          end else begin
            state_q <= StIdle;
          end
        end
        StLat: begin
          if (lat_q == 16'(READ_LATENCY - 1)) begin
            state_q <= StResp;
          end else begin
            lat_q <= lat_q + 16'd1;
          end
        end
        StResp: begin
          beat_q <= beat_q + 3'd1;
          if (beat_q == LastBeat) state_q <= StIdle;
        end
        StWdata: begin
          if (bus_reqcyc) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == LastBeat) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sysbus_mem_array #(
    .DataW (BUS_DATA_WIDTH),
    .Words (MEM_WORDS),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i       (clk),
    .bus_we_i    (wr_beat),
    .bus_idx_i   (beat_idx),
    .bus_wdata_i (bus_req),
    .bd_we_i     (bd_we && (state_q != StWdata)),
    .bd_idx_i    (bd_addr[IdxW+2:3]),
    .bd_wdata_i  (bd_data),
    .rd_idx_i    (beat_idx),
    .rd_data_o   (rd_data)
  );

  assign bus_reqack  = (state_q == StAck) || wr_beat;
  assign bus_respcyc = (state_q == StResp);
  assign bus_resp    = (state_q == StResp) ? rd_data : '0;
  assign bus_resptag = (state_q == StResp) ? tag_q : '0;

  logic unused_bits;
  assign unused_bits = ^{bus_req[2:0], bd_addr[2:0], bd_addr[63:IdxW+3]};

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && (state_q == StResp) && (beat_q != 3'd0)) begin
      assert (bus_respack)
        else $error("sysbus_mem_responder: respack low on beat %0d", beat_q);
    end
    if (!reset && (state_q == StIdle) && req_hit && (|(bus_req >> (3 + IdxW)))) begin
      $warning("sysbus_mem_responder: address %h aliases modulo array size", bus_req);
    end
  end
`endif

endmodule
